// File: rtl/fp_chk_pkg.sv
// Shared types and float classification helpers for the FNMADD result checker.
package fp_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } chk_state_e;

  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned SP_MAN_W = 23;
  localparam int unsigned DP_EXP_W = 11;
  localparam int unsigned DP_MAN_W = 52;

  // Values are zero-extended to 64 bits; width selects single or double layout.
  function automatic logic is_nan(input logic [63:0] v, input int unsigned width);
    if (width == 64) return (&v[62:52]) && (|v[51:0]);
    return (&v[30:23]) && (|v[22:0]);
  endfunction

  function automatic logic is_inf(input logic [63:0] v, input int unsigned width);
    if (width == 64) return (&v[62:52]) && (v[51:0] == '0);
    return (&v[30:23]) && (v[22:0] == '0);
  endfunction

  function automatic logic is_zero(input logic [63:0] v, input int unsigned width);
    if (width == 64) return v[62:0] == '0;
    return v[30:0] == '0;
  endfunction

endpackage

// File: rtl/fma_result_checker_if.sv
// Expected-value push and DUT-result strobe between the driver and the checker.
interface fma_result_checker_if #(
  parameter int unsigned WIDTH = 32
);
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;

  modport master (output exp_valid, exp_data, res_valid, res_data, input exp_ready);
  modport slave  (input exp_valid, exp_data, res_valid, res_data, output exp_ready);
endinterface

// File: rtl/fp_chk_fifo.sv
// Expected-value FIFO: registered pointers with wrap bit, registered full/empty.
module fp_chk_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             full_q, full_d, empty_q, empty_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full_q)  wr_d = wr_q + (AW+1)'(1);
      if (pop  && !empty_q) rd_d = rd_q + (AW+1)'(1);
    end
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset; occupancy comes from the pointers.
  always_ff @(posedge clk) begin
    if (push && !full_q && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata_c = mem_q[rd_q[AW-1:0]];
  assign full    = full_q;
  assign empty   = empty_q;
endmodule

// File: rtl/fma_result_checker.sv
// Receive-side checker for FNMADD results: queues expected values, compares DUT results.
// Optional FMA_CHK_ULP_EN adds a same-sign ULP_TOL tolerance for finite values.
module fma_result_checker
  import fp_chk_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
`ifdef FMA_CHK_ULP_EN
  , parameter int unsigned ULP_TOL = 1
`endif
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_vectors,
  fma_result_checker_if.slave  bus,
  output logic [CNT_W-1:0]     checked_cnt,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W-1:0]     first_bad_idx,
  output logic [WIDTH-1:0]     first_bad_exp,
  output logic [WIDTH-1:0]     first_bad_got,
  output logic                 underflow_err,
  output logic                 timeout_err,
  output logic                 done,
  output logic                 pass
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, checked_q, checked_d, mism_q, mism_d, fb_idx_q, fb_idx_d;
  logic [WIDTH-1:0] fb_exp_q, fb_exp_d, fb_got_q, fb_got_d;
  logic             under_q, under_d, tmo_err_q, tmo_err_d, done_q, done_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             fifo_clr, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] head_c;
  logic             match_c;

  fp_chk_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .RST     (RST),
    .clr     (fifo_clr),
    .push    (fifo_push),
    .wdata   (bus.exp_data),
    .pop     (fifo_pop),
    .rdata_c (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.exp_ready = (state_q == S_RUN) && !fifo_full;
  assign fifo_push     = bus.exp_valid && bus.exp_ready;

  // NaN/NaN and +0/-0 are equal; everything else must match bit for bit.
  always_comb begin
    logic e_nan, g_nan;
    e_nan   = is_nan(64'(head_c), WIDTH);
    g_nan   = is_nan(64'(bus.res_data), WIDTH);
    match_c = (e_nan && g_nan)
           || (is_zero(64'(head_c), WIDTH) && is_zero(64'(bus.res_data), WIDTH))
           || (!e_nan && !g_nan && head_c == bus.res_data);
`ifdef FMA_CHK_ULP_EN
    begin
      logic [WIDTH-2:0] mag_e, mag_g, dist;
      mag_e = head_c[WIDTH-2:0];
      mag_g = bus.res_data[WIDTH-2:0];
      dist  = (mag_e >= mag_g) ? (mag_e - mag_g) : (mag_g - mag_e);
      if (!e_nan && !g_nan && !is_inf(64'(head_c), WIDTH) && !is_inf(64'(bus.res_data), WIDTH)
          && head_c[WIDTH-1] == bus.res_data[WIDTH-1] && dist <= (WIDTH-1)'(ULP_TOL))
        match_c = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    checked_d = checked_q;
    mism_d    = mism_q;
    fb_idx_d  = fb_idx_q;
    fb_exp_d  = fb_exp_q;
    fb_got_d  = fb_got_q;
    under_d   = under_q;
    tmo_err_d = tmo_err_q;
    tmo_d     = tmo_q;
    fifo_clr  = 1'b0;
    fifo_pop  = 1'b0;

    if (start && state_q != S_RUN) begin
      state_d   = S_RUN;
      n_d       = n_vectors;
      checked_d = '0;
      mism_d    = '0;
      fb_idx_d  = '0;
      fb_exp_d  = '0;
      fb_got_d  = '0;
      under_d   = 1'b0;
      tmo_err_d = 1'b0;
      tmo_d     = '0;
      fifo_clr  = 1'b1;
    end else if (state_q == S_RUN) begin
      if (bus.res_valid) begin
        tmo_d = '0;
        if (fifo_empty) begin
          under_d = 1'b1;
        end else begin
          fifo_pop  = 1'b1;
          checked_d = (&checked_q) ? checked_q : checked_q + CNT_W'(1);
          if (!match_c) begin
            mism_d = (&mism_q) ? mism_q : mism_q + CNT_W'(1);
            if (mism_q == '0) begin
              fb_idx_d = checked_q;
              fb_exp_d = head_c;
              fb_got_d = bus.res_data;
            end
          end
        end
      end else if (!fifo_empty) begin
        if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end else begin
        tmo_d = '0;
      end
      if (checked_q == n_q) state_d = S_DONE;
    end else if (state_q == S_DONE) begin
      if (bus.res_valid) under_d = 1'b1;
    end else begin
      state_d = S_IDLE;
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      checked_q <= '0;
      mism_q    <= '0;
      fb_idx_q  <= '0;
      fb_exp_q  <= '0;
      fb_got_q  <= '0;
      under_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      checked_q <= checked_d;
      mism_q    <= mism_d;
      fb_idx_q  <= fb_idx_d;
      fb_exp_q  <= fb_exp_d;
      fb_got_q  <= fb_got_d;
      under_q   <= under_d;
      tmo_err_q <= tmo_err_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
    end
  end

  assign checked_cnt   = checked_q;
  assign mismatch_cnt  = mism_q;
  assign first_bad_idx = fb_idx_q;
  assign first_bad_exp = fb_exp_q;
  assign first_bad_got = fb_got_q;
  assign underflow_err = under_q;
  assign timeout_err   = tmo_err_q;
  assign done          = done_q;
  assign pass          = done_q && (mism_q == '0) && !under_q && !tmo_err_q;
endmodule
